// File: rtl/pipe_pclk_rate_ctrl_if.sv
// PIPE PCLK rate-control bus: lane rate requests, lock, force override and
// the select/status outputs of the controller.
interface pipe_pclk_rate_ctrl_if #(
  parameter int PCIE_LANE = 8,
  parameter int NUM_CLK   = 3
);
  logic [2*PCIE_LANE-1:0] pclk_sel_in;
  logic [PCIE_LANE-1:0]   lane_active;
  logic                   mmcm_locked;
  logic                   force_en;
  logic [1:0]             force_rate;
  logic [NUM_CLK-1:0]     clk_sel;
  logic [1:0]             cur_rate;
  logic                   switch_busy;
  logic                   switch_done;
  logic                   lane_mismatch;
  logic [15:0]            switch_count;

  modport master (
    output pclk_sel_in, lane_active, mmcm_locked, force_en, force_rate,
    input  clk_sel, cur_rate, switch_busy, switch_done, lane_mismatch, switch_count
  );

  modport slave (
    input  pclk_sel_in, lane_active, mmcm_locked, force_en, force_rate,
    output clk_sel, cur_rate, switch_busy, switch_done, lane_mismatch, switch_count
  );
endinterface

// File: rtl/pipe_pclk_rate_ctrl.sv
// PCLK source select controller: synchronises per-lane rate requests,
// qualifies lane agreement and drives a break-before-make one-hot select.
module pipe_pclk_rate_ctrl #(
  parameter int PCIE_LANE     = 8,
  parameter int NUM_CLK       = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 8
) (
  input logic                  sys_clk,
  input logic                  sys_reset_n,
  pipe_pclk_rate_ctrl_if.slave bus
);

  localparam logic [2:0]  NumClkW = 3'(NUM_CLK);
  localparam logic [15:0] StableW = 16'(STABLE_CYCLES);
  localparam logic [15:0] GapW    = 16'(GAP_CYCLES);
  localparam logic [15:0] SettleW = 16'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_QUALIFY, S_BREAK, S_GAP, S_MAKE, S_SETTLE
  } stateT;

  stateT                  state_q, state_d;
  logic [2*PCIE_LANE-1:0] selSync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] lockSync_q;
  logic [15:0]            cnt_q, cnt_d;
  logic [1:0]             latched_q, latched_d;
  logic [1:0]             curRate_q, curRate_d;
  logic [NUM_CLK-1:0]     clkSel_q, clkSel_d;
  logic                   done_q, done_d;
  logic                   mismatch_q;
  logic [15:0]            switchCount_q;
  logic                   countInc;

  logic [2*PCIE_LANE-1:0] selSynced;
  logic                   locked;
  logic                   agreeFound, laneDisagree, laneIllegal, agreeValid;
  logic [1:0]             agreeCode;
  logic [1:0]             targetCode;
  logic                   targetValid;

  assign selSynced = selSync_q[SYNC_STAGES-1];
  assign locked    = lockSync_q[SYNC_STAGES-1];

  // Shift asynchronous lane codes and MMCM lock through the synchroniser chains.
  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) selSync_q[s] <= '0;
      lockSync_q <= '0;
    end else begin
      selSync_q[0] <= bus.pclk_sel_in;
      for (int s = 1; s < SYNC_STAGES; s++) selSync_q[s] <= selSync_q[s-1];
      lockSync_q <= {lockSync_q[SYNC_STAGES-2:0], bus.mmcm_locked};
    end
  end

  // Compare every active lane against the first active lane; flag code 3 as illegal.
  always_comb begin
    agreeFound   = 1'b0;
    agreeCode    = 2'd0;
    laneDisagree = 1'b0;
    laneIllegal  = 1'b0;
    for (int i = 0; i < PCIE_LANE; i++) begin
      if (bus.lane_active[i]) begin
        if (selSynced[2*i +: 2] == 2'd3) laneIllegal = 1'b1;
        if (!agreeFound) begin
          agreeFound = 1'b1;
          agreeCode  = selSynced[2*i +: 2];
        end else if (selSynced[2*i +: 2] != agreeCode) begin
          laneDisagree = 1'b1;
        end
      end
    end
  end

  assign agreeValid  = agreeFound && !laneIllegal && !laneDisagree &&
                       ({1'b0, agreeCode} < NumClkW);
  assign targetCode  = bus.force_en ? bus.force_rate : agreeCode;
  assign targetValid = bus.force_en ? ({1'b0, bus.force_rate} < NumClkW) : agreeValid;

  // Switch sequencing: qualify a stable target, break, gap, make on lock, settle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latched_d = latched_q;
    curRate_d = curRate_q;
    clkSel_d  = clkSel_q;
    done_d    = 1'b0;
    countInc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (targetValid && (targetCode != curRate_q) && locked) begin
          state_d   = S_QUALIFY;
          latched_d = targetCode;
          cnt_d     = 16'd1;
        end
      end
      S_QUALIFY: begin
        if (!targetValid || (targetCode == curRate_q)) begin
          state_d = S_IDLE;
        end else if (targetCode != latched_q) begin
          latched_d = targetCode;
          cnt_d     = 16'd1;
        end else if (locked) begin
          if (cnt_q >= StableW) state_d = S_BREAK;
          else                  cnt_d   = cnt_q + 16'd1;
        end
      end
      S_BREAK: begin
        clkSel_d = '0;
        cnt_d    = 16'd1;
        state_d  = (GAP_CYCLES == 0) ? S_MAKE : S_GAP;
      end
      S_GAP: begin
        if (cnt_q >= GapW) state_d = S_MAKE;
        else               cnt_d   = cnt_q + 16'd1;
      end
      S_MAKE: begin
        if (locked) begin
          clkSel_d  = NUM_CLK'(1) << latched_q;
          curRate_d = latched_q;
          cnt_d     = 16'd1;
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q >= SettleW) begin
          done_d   = 1'b1;
          countInc = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register FSM state, select, status and the saturating switch counter.
  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      latched_q     <= '0;
      curRate_q     <= '0;
      clkSel_q      <= NUM_CLK'(1);
      done_q        <= 1'b0;
      mismatch_q    <= 1'b0;
      switchCount_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      latched_q  <= latched_d;
      curRate_q  <= curRate_d;
      clkSel_q   <= clkSel_d;
      done_q     <= done_d;
      mismatch_q <= laneIllegal | laneDisagree;
      if (countInc && (switchCount_q != 16'hFFFF)) switchCount_q <= switchCount_q + 16'd1;
    end
  end

  assign bus.clk_sel       = clkSel_q;
  assign bus.cur_rate      = curRate_q;
  assign bus.switch_busy   = (state_q == S_BREAK) || (state_q == S_GAP) ||
                             (state_q == S_MAKE)  || (state_q == S_SETTLE);
  assign bus.switch_done   = done_q;
  assign bus.lane_mismatch = mismatch_q;
  assign bus.switch_count  = switchCount_q;

endmodule

// File: tb/tb_pipe_pclk_rate_ctrl.sv
// Self-checking bench for pipe_pclk_rate_ctrl: vector table plus hand-written
// multi-cycle sequences, with expectations queued and compared at quiescence.
module tb_pipe_pclk_rate_ctrl;

  logic sys_clk = 1'b0;
  logic sys_reset_n;

  pipe_pclk_rate_ctrl_if #(.PCIE_LANE(8), .NUM_CLK(3)) ifc ();

  pipe_pclk_rate_ctrl #(
    .PCIE_LANE(8), .NUM_CLK(3), .SYNC_STAGES(2),
    .STABLE_CYCLES(4), .GAP_CYCLES(2), .SETTLE_CYCLES(8)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .bus         (ifc)
  );

  typedef struct packed {
    logic [15:0] codes;
    logic [7:0]  active;
    logic        forceEn;
    logic [1:0]  forceRate;
    logic [1:0]  expRate;
    logic        expMis;
    logic        expSw;
  } vecT;

  typedef struct packed {
    logic [1:0]  rate;
    logic        mis;
    logic [15:0] count;
    logic [7:0]  doneDelta;
    logic        timing;
  } expT;

  vecT  vecs [10];
  expT  expQ [$];
  int   checks = 0;
  int   errors = 0;
  logic [15:0] expCount = 16'd0;
  int   doneBase = 0;

  int   cycle = 0;
  int   doneCnt = 0;
  int   zeroRun = 0;
  int   lastZeroRun = 0;
  int   makeCycle = 0;
  int   settleDelay = 0;
  int   multiHot = 0;
  bit   busySeen = 1'b0;
  logic [2:0] prevSel = 3'b001;

  // Free-running DCLK.
  always #5 sys_clk = ~sys_clk;

  // Observe outputs on the falling edge: done pulses, zero-select window, settle delay.
  always @(negedge sys_clk) begin
    cycle++;
    if (ifc.switch_done) begin
      doneCnt++;
      settleDelay = cycle - makeCycle;
    end
    if ($countones(ifc.clk_sel) > 1) multiHot++;
    if (ifc.switch_busy) busySeen = 1'b1;
    if (ifc.clk_sel == 3'b000) begin
      zeroRun++;
    end else begin
      if (prevSel == 3'b000) begin
        lastZeroRun = zeroRun;
        makeCycle   = cycle;
      end
      zeroRun = 0;
    end
    prevSel = ifc.clk_sel;
  end

  // Runaway guard.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  task automatic checkVal(input string name, input int idx,
                          input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [15:0] satInc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  task automatic pushExp(input logic [1:0] rate, input logic mis,
                         input logic sw, input logic timing);
    expT e;
    if (sw) expCount = satInc(expCount);
    doneBase    = doneCnt;
    e.rate      = rate;
    e.mis       = mis;
    e.count     = expCount;
    e.doneDelta = sw ? 8'd1 : 8'd0;
    e.timing    = timing;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input vecT v);
    ifc.pclk_sel_in = v.codes;
    ifc.lane_active = v.active;
    ifc.force_en    = v.forceEn;
    ifc.force_rate  = v.forceRate;
    pushExp(v.expRate, v.expMis, v.expSw, v.expSw);
  endtask

  task automatic checkOutput(input int idx);
    expT e;
    logic [2:0] oneHot;
    if (expQ.size() == 0) begin
      checkVal("scoreboard_empty", idx, 32'd0, 32'd1);
      return;
    end
    e = expQ.pop_front();
    oneHot = 3'b001 << e.rate;
    checkVal("cur_rate", idx, 32'(ifc.cur_rate), 32'(e.rate));
    checkVal("clk_sel", idx, 32'(ifc.clk_sel), 32'(oneHot));
    checkVal("lane_mismatch", idx, 32'(ifc.lane_mismatch), 32'(e.mis));
    checkVal("switch_count", idx, 32'(ifc.switch_count), 32'(e.count));
    checkVal("done_pulses", idx, 32'(doneCnt - doneBase), 32'(e.doneDelta));
    checkVal("busy_quiet", idx, 32'(ifc.switch_busy), 32'd0);
    if (e.timing) begin
      checkVal("zero_window", idx, 32'(lastZeroRun), 32'd3);
      checkVal("settle_delay", idx, 32'(settleDelay), 32'd8);
    end
  endtask

  task automatic waitSelZero(input int idx, input int maxCycles);
    int n = 0;
    while ((ifc.clk_sel != 3'b000) && (n < maxCycles)) begin
      tick(1);
      n++;
    end
    if (ifc.clk_sel != 3'b000) checkVal("wait_break", idx, 32'(ifc.clk_sel), 32'd0);
  endtask

  initial begin
    int nonZero;

    vecs[0] = '{codes:16'h0040, active:8'hFF, forceEn:1'b0, forceRate:2'd0, expRate:2'd0, expMis:1'b1, expSw:1'b0};
    vecs[1] = '{codes:16'h0040, active:8'hF7, forceEn:1'b0, forceRate:2'd0, expRate:2'd0, expMis:1'b0, expSw:1'b0};
    vecs[2] = '{codes:16'h5555, active:8'hFF, forceEn:1'b0, forceRate:2'd0, expRate:2'd1, expMis:1'b0, expSw:1'b1};
    vecs[3] = '{codes:16'hEAAA, active:8'hFF, forceEn:1'b0, forceRate:2'd0, expRate:2'd1, expMis:1'b1, expSw:1'b0};
    vecs[4] = '{codes:16'hAAAA, active:8'hFF, forceEn:1'b0, forceRate:2'd0, expRate:2'd2, expMis:1'b0, expSw:1'b1};
    vecs[5] = '{codes:16'h0000, active:8'h00, forceEn:1'b0, forceRate:2'd0, expRate:2'd2, expMis:1'b0, expSw:1'b0};
    vecs[6] = '{codes:16'hAAAA, active:8'hFF, forceEn:1'b1, forceRate:2'd0, expRate:2'd0, expMis:1'b0, expSw:1'b1};
    vecs[7] = '{codes:16'hAAAA, active:8'hFF, forceEn:1'b1, forceRate:2'd3, expRate:2'd0, expMis:1'b0, expSw:1'b0};
    vecs[8] = '{codes:16'hFFF5, active:8'h03, forceEn:1'b0, forceRate:2'd0, expRate:2'd1, expMis:1'b0, expSw:1'b1};
    vecs[9] = '{codes:16'h0000, active:8'hFF, forceEn:1'b0, forceRate:2'd0, expRate:2'd0, expMis:1'b0, expSw:1'b1};

    sys_reset_n     = 1'b0;
    ifc.pclk_sel_in = 16'h0000;
    ifc.lane_active = 8'hFF;
    ifc.mmcm_locked = 1'b1;
    ifc.force_en    = 1'b0;
    ifc.force_rate  = 2'd0;
    tick(3);
    pushExp(2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput(100);

    sys_reset_n = 1'b1;
    busySeen    = 1'b0;
    pushExp(2'd0, 1'b0, 1'b0, 1'b0);
    tick(100);
    checkVal("idle_no_busy", 101, 32'(busySeen), 32'd0);
    checkOutput(101);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      tick(60);
      checkOutput(i);
    end

    $display("[TB] glitch shorter than qualification window");
    busySeen = 1'b0;
    pushExp(2'd0, 1'b0, 1'b0, 1'b0);
    ifc.pclk_sel_in = 16'h5555;
    tick(3);
    ifc.pclk_sel_in = 16'h0000;
    tick(40);
    checkVal("glitch_no_busy", 200, 32'(busySeen), 32'd0);
    checkOutput(200);

    $display("[TB] no switch while unlocked");
    busySeen = 1'b0;
    ifc.mmcm_locked = 1'b0;
    ifc.pclk_sel_in = 16'h5555;
    tick(40);
    checkVal("unlocked_no_busy", 201, 32'(busySeen), 32'd0);
    checkVal("unlocked_sel", 201, 32'(ifc.clk_sel), 32'd1);
    pushExp(2'd1, 1'b0, 1'b1, 1'b1);
    ifc.mmcm_locked = 1'b1;
    tick(60);
    checkOutput(201);

    $display("[TB] retarget during qualification");
    pushExp(2'd0, 1'b0, 1'b1, 1'b1);
    ifc.pclk_sel_in = 16'h0000;
    tick(60);
    checkOutput(202);
    pushExp(2'd2, 1'b0, 1'b1, 1'b1);
    ifc.pclk_sel_in = 16'h5555;
    tick(2);
    ifc.pclk_sel_in = 16'hAAAA;
    tick(60);
    checkOutput(203);

    $display("[TB] lock loss during gap");
    pushExp(2'd0, 1'b0, 1'b1, 1'b1);
    ifc.pclk_sel_in = 16'h0000;
    tick(60);
    checkOutput(204);
    pushExp(2'd2, 1'b0, 1'b1, 1'b0);
    ifc.force_en   = 1'b1;
    ifc.force_rate = 2'd2;
    waitSelZero(205, 40);
    ifc.mmcm_locked = 1'b0;
    nonZero = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (ifc.clk_sel != 3'b000) nonZero++;
    end
    checkVal("unlocked_gap_hold", 205, 32'(nonZero), 32'd0);
    ifc.mmcm_locked = 1'b1;
    tick(40);
    checkOutput(205);

    $display("[TB] reset during gap");
    ifc.force_rate = 2'd1;
    waitSelZero(206, 40);
    sys_reset_n     = 1'b0;
    ifc.force_en    = 1'b0;
    ifc.pclk_sel_in = 16'h0000;
    tick(1);
    expCount = 16'd0;
    pushExp(2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput(206);
    sys_reset_n = 1'b1;
    pushExp(2'd0, 1'b0, 1'b0, 1'b0);
    tick(40);
    checkOutput(207);

    $display("[TB] switch counter saturation");
    force dut.switchCount_q = 16'hFFFD;
    tick(1);
    release dut.switchCount_q;
    expCount = 16'hFFFD;
    ifc.force_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [1:0] r;
      r = (k == 0) ? 2'd1 : ((k == 1) ? 2'd0 : 2'd2);
      pushExp(r, 1'b0, 1'b1, 1'b1);
      ifc.force_rate = r;
      tick(60);
      checkOutput(300 + k);
    end

    checkVal("never_multi_hot", 400, 32'(multiHot), 32'd0);
    checkVal("scoreboard_drained", 401, 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_pclk_rate_ctrl.md
Name: pipe_pclk_rate_ctrl

Overview:
- Parametrised successor to the fixed two-clock PCLK select logic in the 7-series PCIe wrapper.
- Collects per-lane PIPE rate requests (Gen1/Gen2/Gen3) from the hard block, over a lane-active mask.
- Qualifies lane agreement, then drives a break-before-make one-hot select for up to NUM_CLK BUFGCTRL/BUFGMUX inputs.
- Runs on the free-running DCLK domain; adds a force override, lock gating and status/statistics outputs.

Parameters:
PCIE_LANE, 8, number of lanes (1..16)
NUM_CLK, 3, number of selectable PCLK sources; rate code r selects source r
SYNC_STAGES, 2, synchroniser depth on lane rate inputs (>=2)
STABLE_CYCLES, 4, cycles a new agreed target must hold before switching (>=1)
GAP_CYCLES, 2, extra all-deselected cycles between break and make (>=0)
SETTLE_CYCLES, 8, cycles after make before done/idle (>=1)

Ports:
sys_clk  in  1  single clock for all logic (free-running DCLK)
sys_reset_n  in  1  synchronous, active-low reset
pclk_sel_in  in  2*PCIE_LANE  per-lane rate code, lane i at [2i+1:2i]; asynchronous to sys_clk
lane_active  in  PCIE_LANE  1 = lane participates in agreement
mmcm_locked  in  1  PCLK source MMCM locked (synchronised internally)
force_en  in  1  1 = use force_rate instead of lane agreement
force_rate  in  2  forced rate code
clk_sel  out  NUM_CLK  one-hot buffer select; all-zero during the gap
cur_rate  out  2  rate currently selected
switch_busy  out  1  high in BREAK, GAP, MAKE and SETTLE
switch_done  out  1  one-cycle pulse on SETTLE exit
lane_mismatch  out  1  active lanes' synchronised codes disagree, or any active code is 3
switch_count  out  16  completed switches, saturates at 16'hFFFF

Behaviour:
- Reset (sys_reset_n=0 at a sys_clk edge): clk_sel=1 (source 0), cur_rate=0, switch_busy=0, switch_done=0, lane_mismatch=0, switch_count=0, state=IDLE. All synchroniser flops are cleared. Reset mid-switch returns to these values on the next edge.
- Synchronisation: pclk_sel_in and mmcm_locked pass through SYNC_STAGES flops. All decisions use synchronised values only.
- Agreement is valid when lane_active!=0, all active synced codes are equal and !=3, and the code is <NUM_CLK.
  - lane_mismatch is registered: one cycle after the synced inputs.
  - Inactive lanes are ignored.
- target = force_rate if force_en, else the agreed code. A force_rate >= NUM_CLK is treated as invalid.
- FSM:
  - IDLE: if target valid, target!=cur_rate and locked -> QUALIFY; latch target, qcnt=1.
  - QUALIFY:
    - target invalid or target==cur_rate -> IDLE.
    - target != latched -> relatch target, qcnt=1.
    - else qcnt++; when qcnt==STABLE_CYCLES and locked -> BREAK.
    - If lock drops, hold qcnt.
  - BREAK (1 cycle): clk_sel<=0 -> GAP.
  - GAP: clk_sel stays 0 for GAP_CYCLES cycles -> MAKE. If GAP_CYCLES=0, go directly to MAKE.
  - MAKE: wait while !locked with clk_sel=0. When locked: clk_sel<=onehot(latched), cur_rate<=latched -> SETTLE.
  - SETTLE: count SETTLE_CYCLES, ignoring input changes. On the final cycle: switch_done=1 for one cycle, switch_count+=1 (saturating) -> IDLE.
- Zero-select window: at least 1+GAP_CYCLES cycles. clk_sel is never multi-hot.
- A change in force_en or target during BREAK..SETTLE is not acted on until IDLE is re-entered; it is then re-evaluated normally.
- No switch is ever started while locked=0.
- NUM_CLK=2 restricts valid codes to 0 and 1; Gen3 requests then report lane_mismatch=0 but are invalid targets (no switch).

Test Plan:
- After reset, all 8 lanes active, codes=0 -> clk_sel=3'b001, cur_rate=0, busy=0, count=0, no activity for 100 cycles.
- All lanes step to code 1, held, locked=1 -> clk_sel goes 000 for exactly 3 cycles, then 010; cur_rate=1; switch_done pulses once, SETTLE_CYCLES=8 cycles after make; switch_count=1.
- Lane 3 code=1 with others 0, all active -> lane_mismatch=1, no switch. Then clear lane_active[3] -> mismatch=0, still no switch (agreed 0 == cur_rate).
- Target toggles 0->1 for 3 synced cycles then back to 0 -> FSM returns to IDLE, clk_sel unchanged, count unchanged. A 1->2 change mid-QUALIFY restarts qualification and ends selecting 3'b100.
- force_en=1, force_rate=2 while lanes report 0 -> switch to 3'b100. Drop mmcm_locked during GAP -> clk_sel held 000 until relock, then 100.
- Assert sys_reset_n=0 during GAP -> next edge clk_sel=001, busy=0, cur_rate=0. With switch_count preset via 65535 switches, a further switch -> count stays 16'hFFFF.
